// File: rtl/arith_share_sched_if.sv
// Requester-side bus of the shared arithmetic scheduler: job requests in, one-hot accept/response out.
interface arith_share_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_val;
  logic                  rsp_ovf;
  logic                  rsp_dbz;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_val, rsp_ovf, rsp_dbz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_val, rsp_ovf, rsp_dbz
  );
endinterface

// File: rtl/arith_share_sched.sv
// Round-robin scheduler sharing one iterative mul/div engine among NREQ requesters,
// with local divide-by-zero short-circuit and a sticky engine timeout.
module arith_share_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  arith_share_sched_if.slave bus,
  output logic               eng_start_o,
  output logic               eng_op_o,
  output logic [WIDTH-1:0]   eng_a_o,
  output logic [WIDTH-1:0]   eng_b_o,
  input  logic               eng_done_i,
  input  logic [WIDTH-1:0]   eng_val_i,
  input  logic               eng_ovf_i,
  input  logic               eng_dbz_i,
  output logic               busy_o,
  output logic               error_to_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_val_q, rsp_val_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic             eng_start_q, eng_start_d;
  logic             eng_op_q, eng_op_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d;
  logic [WIDTH-1:0] eng_b_q, eng_b_d;
  logic             busy_q, busy_d;
  logic             error_to_q, error_to_d;

  logic             found_c;
  logic [PW-1:0]    grant_idx_c;
  int unsigned      scan_c;
  logic             sel_op_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  logic [PW-1:0]    next_ptr_c;

  // First pending requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    found_c     = 1'b0;
    grant_idx_c = '0;
    scan_c      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_c = 32'(rr_ptr_q) + i;
      if (scan_c >= NREQ) scan_c = scan_c - NREQ;
      if (!found_c && bus.req_valid[PW'(scan_c)]) begin
        found_c     = 1'b1;
        grant_idx_c = PW'(scan_c);
      end
    end
    sel_op_c   = bus.req_op[grant_idx_c];
    sel_a_c    = bus.req_a[grant_idx_c*WIDTH +: WIDTH];
    sel_b_c    = bus.req_b[grant_idx_c*WIDTH +: WIDTH];
    next_ptr_c = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_val_d   = rsp_val_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_dbz_d   = rsp_dbz_q;
    eng_start_d = 1'b0;
    eng_op_d    = eng_op_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    error_to_d  = error_to_q;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          grant_d     = grant_idx_c;
          eng_op_d    = sel_op_c;
          eng_a_d     = sel_a_c;
          eng_b_d     = sel_b_c;
          req_ready_d = NREQ'(1) << grant_idx_c;
          // Start is registered, so the zero-divisor decision is made here
          eng_start_d = !(sel_op_c && (sel_b_c == '0));
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_op_q && (eng_b_q == '0)) begin
          rsp_val_d   = '0;
          rsp_ovf_d   = 1'b0;
          rsp_dbz_d   = 1'b1;
          rsp_valid_d = NREQ'(1) << grant_q;
          state_d     = S_RESP;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done_i) begin
          rsp_val_d   = eng_val_i;
          rsp_ovf_d   = eng_ovf_i;
          rsp_dbz_d   = eng_dbz_i;
          rsp_valid_d = NREQ'(1) << grant_q;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_val_d   = '0;
          rsp_ovf_d   = 1'b1;
          rsp_dbz_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << grant_q;
          error_to_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        rr_ptr_d = next_ptr_c;
        state_d  = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        error_to_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_val_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_dbz_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_op_q    <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      busy_q      <= 1'b0;
      error_to_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_val_q   <= rsp_val_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_dbz_q   <= rsp_dbz_d;
      eng_start_q <= eng_start_d;
      eng_op_q    <= eng_op_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      busy_q      <= busy_d;
      error_to_q  <= error_to_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_val   = rsp_val_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_dbz   = rsp_dbz_q;
  assign eng_start_o   = eng_start_q;
  assign eng_op_o      = eng_op_q;
  assign eng_a_o       = eng_a_q;
  assign eng_b_o       = eng_b_q;
  assign busy_o        = busy_q;
  assign error_to_o    = error_to_q;

endmodule

// File: tb/tb_arith_share_sched.sv
// Scoreboard bench for arith_share_sched with a 4-fraction-bit fixed-point engine model.
module tb_arith_share_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned LAT     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arith_share_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic             eng_start, eng_op, eng_done, eng_ovf, eng_dbz, busy, error_to;
  logic [WIDTH-1:0] eng_a, eng_b, eng_val;

  arith_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .eng_start_o(eng_start),
    .eng_op_o   (eng_op),
    .eng_a_o    (eng_a),
    .eng_b_o    (eng_b),
    .eng_done_i (eng_done),
    .eng_val_i  (eng_val),
    .eng_ovf_i  (eng_ovf),
    .eng_dbz_i  (eng_dbz),
    .busy_o     (busy),
    .error_to_o (error_to)
  );

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   lat_cnt = 0;
  logic hang = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Engine model: Q4 fixed point, saturating, result LAT cycles after start
  function automatic logic [16:0] eng_calc(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] r;
    if (!op) r = ($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b})) >>> 4;
    else if (b == 16'h0) r = 32'sd0;
    else r = ($signed({{16{a[15]}}, a}) <<< 4) / $signed({{16{b[15]}}, b});
    if (r > 32'sd32767)  return {1'b1, 16'h7FFF};
    if (r < -32'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_done <= 1'b0;
      eng_val  <= '0;
      eng_ovf  <= 1'b0;
      eng_dbz  <= 1'b0;
      lat_cnt  <= 0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        lat_cnt <= LAT;
        starts  <= starts + 1;
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1 && !hang) begin
          eng_done <= 1'b1;
          {eng_ovf, eng_val} <= eng_calc(eng_op, eng_a, eng_b);
          eng_dbz <= eng_op && (eng_b == 16'h0);
        end
      end
    end
  end

  // Monitor: every response pulse pops and checks the oldest expected job
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (|bus.rsp_valid)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=%b, expected no response", bus.rsp_valid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001 << mon_e.idx));
          chk("rsp_val", 64'(bus.rsp_val), 64'(mon_e.val));
          chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(mon_e.ovf));
          chk("rsp_dbz", 64'(bus.rsp_dbz), 64'(mon_e.dbz));
        end
      end
    end
  end

  // Advance to the next falling edge; requesters drop a job once accepted
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic post(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]              = 1'b1;
    bus.req_op[i]                 = op;
    bus.req_a[i*WIDTH +: WIDTH]   = a;
    bus.req_b[i*WIDTH +: WIDTH]   = b;
  endtask

  task automatic expect_rsp(input int i, input logic [15:0] v, input logic o, input logic d);
    exp_t e;
    e.idx = i; e.val = v; e.ovf = o; e.dbz = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (|bus.rsp_valid) break;
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL wait_rsp: no rsp_valid within %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy) begin
      tick();
      n++;
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d responses outstanding, busy=%b", exp_q.size(), busy);
        break;
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_val, bus.rsp_ovf, bus.rsp_dbz,
                eng_start, eng_op, eng_a, eng_b, busy, error_to});
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int s0;

    // Single multiply, 3.0 * 2.0
    do_reset();
    post(0, 1'b0, 16'h0030, 16'h0020);
    expect_rsp(0, 16'h0060, 1'b0, 1'b0);
    tick();
    chk("t1_req_ready", 64'(bus.req_ready), 64'h1);
    chk("t1_eng_start", 64'(eng_start), 64'h1);
    chk("t1_eng_ab", 64'({eng_op, eng_a, eng_b}), 64'h0_0030_0020);
    chk("t1_busy", 64'(busy), 64'h1);
    wait_rsp(n);
    chk("t1_rsp_cycle", 64'(1 + n), 64'(LAT + 3));
    drain();

    // Four simultaneous requests, then 0 and 2 together
    do_reset();
    post(0, 1'b0, 16'h0010, 16'h0010);
    post(1, 1'b0, 16'h0020, 16'h0030);
    post(2, 1'b1, 16'h0040, 16'h0020);
    post(3, 1'b0, 16'hFFF0, 16'h0020);
    expect_rsp(0, 16'h0010, 1'b0, 1'b0);
    expect_rsp(1, 16'h0060, 1'b0, 1'b0);
    expect_rsp(2, 16'h0020, 1'b0, 1'b0);
    expect_rsp(3, 16'hFFE0, 1'b0, 1'b0);
    drain();
    post(0, 1'b0, 16'h0008, 16'h0040);
    post(2, 1'b0, 16'h0050, 16'h0010);
    expect_rsp(0, 16'h0020, 1'b0, 1'b0);
    expect_rsp(2, 16'h0050, 1'b0, 1'b0);
    tick();
    chk("t2_first_grant", 64'(bus.req_ready), 64'h1);
    drain();

    // Divide by zero short-circuit
    s0 = starts;
    post(1, 1'b1, 16'h0010, 16'h0000);
    expect_rsp(1, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("t3_req_ready", 64'(bus.req_ready), 64'h2);
    chk("t3_no_start", 64'(eng_start), 64'h0);
    wait_rsp(n);
    chk("t3_rsp_cycle", 64'(1 + n), 64'd2);
    drain();
    chk("t3_start_count", 64'(starts), 64'(s0));

    // Hung engine hits the timeout; error_to is sticky
    hang = 1'b1;
    post(0, 1'b0, 16'h0030, 16'h0020);
    expect_rsp(0, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("t4_eng_start", 64'(eng_start), 64'h1);
    wait_rsp(n);
    chk("t4_rsp_cycle", 64'(1 + n), 64'(TIMEOUT + 3));
    chk("t4_error_to", 64'(error_to), 64'h1);
    drain();
    hang = 1'b0;
    post(2, 1'b0, 16'h0010, 16'h0010);
    expect_rsp(2, 16'h0010, 1'b0, 1'b0);
    drain();
    chk("t4_error_to_sticky", 64'(error_to), 64'h1);

    // Reset in the middle of a req2 engine wait
    post(2, 1'b0, 16'h0020, 16'h0030);
    tick();
    chk("t5_req_ready", 64'(bus.req_ready), 64'h4);
    tick();
    tick();
    chk("t5_busy_in_wait", 64'(busy), 64'h1);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("t5_reset_outputs", all_outs(), 64'h0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t5_idle_after_reset", all_outs(), 64'h0);
    post(0, 1'b0, 16'h0020, 16'h0020);
    post(3, 1'b0, 16'h7000, 16'h7000);
    expect_rsp(0, 16'h0040, 1'b0, 1'b0);
    expect_rsp(3, 16'h7FFF, 1'b1, 1'b0);
    tick();
    chk("t5_first_grant", 64'(bus.req_ready), 64'h1);
    drain();
    chk("t6_error_to_clear", 64'(error_to), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
